fft_pingpong_sched: RTL

- Frame-level scheduler for the two ping-pong FFT512 engines behind the windowing stage in the STFT power path.
- Assigns each whole windowed frame of N_FFT samples to one idle engine, alternating between engines, and drops a frame when no engine can take it.
- Merges the two engine output streams back into one stream in strict frame-issue order, with start-of-frame and bin-index markers for the power stage.

---
 rtl/fft_pingpong_sched.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/fft_pingpong_sched.sv
// Frame scheduler for two ping-pong FFT engines: issues whole frames to an idle engine,
// alternating between them, and merges engine outputs back in strict frame-issue order.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | input side waiting for a sof sample
// S_FEED1  | forwarding the current frame to engine 1
// S_FEED2  | forwarding the current frame to engine 2
// S_DROP   | swallowing a frame no engine could take
// S_OIDLE  | output side idle, tag queue empty
// S_OUT1   | passing engine 1 bins through (head tag = engine 1)
// S_OUT2   | passing engine 2 bins through (head tag = engine 2)
module fft_pingpong_sched #(
    parameter int WIDTH = 16,
    parameter int N_FFT = 512,
    parameter int CNT_W = $clog2(N_FFT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             win_en,
    input  logic             win_sof,
    input  logic [WIDTH-1:0] win_re,
    input  logic [WIDTH-1:0] win_im,
    input  logic             fft_1_rdy,
    input  logic             fft_2_rdy,
    output logic             fft_1_di_en,
    output logic [WIDTH-1:0] fft_1_di_re,
    output logic [WIDTH-1:0] fft_1_di_im,
    output logic             fft_2_di_en,
    output logic [WIDTH-1:0] fft_2_di_re,
    output logic [WIDTH-1:0] fft_2_di_im,
    input  logic             fft_1_do_en,
    input  logic [WIDTH-1:0] fft_1_do_re,
    input  logic [WIDTH-1:0] fft_1_do_im,
    input  logic             fft_2_do_en,
    input  logic [WIDTH-1:0] fft_2_do_re,
    input  logic [WIDTH-1:0] fft_2_do_im,
    output logic             stft_en,
    output logic             stft_sof,
    output logic [CNT_W-1:0] stft_bin,
    output logic [WIDTH-1:0] stft_re,
    output logic [WIDTH-1:0] stft_im,
    output logic [7:0]       drop_cnt,
    output logic             err,
    output logic             busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED1 = 2'd1;
    localparam logic [1:0] S_FEED2 = 2'd2;
    localparam logic [1:0] S_DROP  = 2'd3;
    localparam logic [1:0] S_OIDLE = 2'd0;
    localparam logic [1:0] S_OUT1  = 2'd1;
    localparam logic [1:0] S_OUT2  = 2'd2;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_FFT - 1);

    // Engine tags are one bit throughout: 0 = engine 1, 1 = engine 2.
    logic [1:0]       in_state, in_state_nxt;
    logic [CNT_W-1:0] in_cnt, in_cnt_nxt;
    logic             last_eng, last_eng_nxt;
    logic [1:0]       out_state, out_state_nxt;
    logic [CNT_W-1:0] out_cnt, out_cnt_nxt;
    logic [1:0]       q_mem, q_mem_nxt;
    logic             q_wr, q_wr_nxt, q_rd, q_rd_nxt;
    logic [1:0]       q_cnt, q_cnt_nxt;
    logic             push, pop, push_tag, sel, sel_en, oth_en;

    logic             d1_en, d2_en, so_en, so_sof, err_nxt, busy_nxt;
    logic [WIDTH-1:0] d1_re, d1_im, d2_re, d2_im, so_re, so_im;
    logic [CNT_W-1:0] so_bin;
    logic [7:0]       drop_nxt;

    always_comb begin
        in_state_nxt  = in_state;
        in_cnt_nxt    = in_cnt;
        last_eng_nxt  = last_eng;
        out_state_nxt = out_state;
        out_cnt_nxt   = out_cnt;
        push = 1'b0; push_tag = 1'b0; pop = 1'b0;
        sel = 1'b0; sel_en = 1'b0; oth_en = 1'b0;
        d1_en = 1'b0; d1_re = '0; d1_im = '0;
        d2_en = 1'b0; d2_re = '0; d2_im = '0;
        so_en = 1'b0; so_sof = 1'b0; so_bin = '0; so_re = '0; so_im = '0;
        drop_nxt = drop_cnt;
        err_nxt  = err;

        case (in_state)
            S_IDLE: begin
                if (win_en) begin
                    if (!win_sof) begin
                        err_nxt = 1'b1;
                    end else if (q_cnt == 2'd2 || !(fft_1_rdy || fft_2_rdy)) begin
                        in_state_nxt = S_DROP;
                        in_cnt_nxt   = CNT_ONE;
                        if (drop_cnt != 8'hFF) drop_nxt = drop_cnt + 8'd1;
                    end else begin
                        push_tag     = (fft_1_rdy && fft_2_rdy) ? ~last_eng : fft_2_rdy;
                        push         = 1'b1;
                        last_eng_nxt = push_tag;
                        in_cnt_nxt   = CNT_ONE;
                        in_state_nxt = push_tag ? S_FEED2 : S_FEED1;
                        if (push_tag) begin
                            d2_en = 1'b1; d2_re = win_re; d2_im = win_im;
                        end else begin
                            d1_en = 1'b1; d1_re = win_re; d1_im = win_im;
                        end
                    end
                end
            end
            default: begin
                // A stray sof mid-frame is flagged but never restarts the frame.
                if (win_en) begin
                    if (win_sof) err_nxt = 1'b1;
                    if (in_state == S_FEED1) begin
                        d1_en = 1'b1; d1_re = win_re; d1_im = win_im;
                    end else if (in_state == S_FEED2) begin
                        d2_en = 1'b1; d2_re = win_re; d2_im = win_im;
                    end
                    if (in_cnt == CNT_LAST) begin
                        in_state_nxt = S_IDLE;
                        in_cnt_nxt   = '0;
                    end else begin
                        in_cnt_nxt = in_cnt + CNT_ONE;
                    end
                end
            end
        endcase

        case (out_state)
            S_OIDLE: begin
                if (fft_1_do_en || fft_2_do_en) err_nxt = 1'b1;
                if (q_cnt != 2'd0) out_state_nxt = q_mem[q_rd] ? S_OUT2 : S_OUT1;
            end
            default: begin
                sel    = (out_state == S_OUT2);
                sel_en = sel ? fft_2_do_en : fft_1_do_en;
                oth_en = sel ? fft_1_do_en : fft_2_do_en;
                if (oth_en) err_nxt = 1'b1;
                if (sel_en) begin
                    so_en  = 1'b1;
                    so_sof = (out_cnt == '0);
                    so_bin = out_cnt;
                    so_re  = sel ? fft_2_do_re : fft_1_do_re;
                    so_im  = sel ? fft_2_do_im : fft_1_do_im;
                    if (out_cnt == CNT_LAST) begin
                        pop         = 1'b1;
                        out_cnt_nxt = '0;
                        // Full queue cannot coincide with a push, so the next head is unambiguous.
                        if (q_cnt == 2'd2)
                            out_state_nxt = q_mem[~q_rd] ? S_OUT2 : S_OUT1;
                        else if (push)
                            out_state_nxt = push_tag ? S_OUT2 : S_OUT1;
                        else
                            out_state_nxt = S_OIDLE;
                    end else begin
                        out_cnt_nxt = out_cnt + CNT_ONE;
                    end
                end
            end
        endcase

        q_mem_nxt = q_mem;
        if (push) q_mem_nxt[q_wr] = push_tag;
        q_wr_nxt  = q_wr ^ push;
        q_rd_nxt  = q_rd ^ pop;
        q_cnt_nxt = q_cnt + {1'b0, push} - {1'b0, pop};
        busy_nxt  = (in_state_nxt == S_FEED1) || (in_state_nxt == S_FEED2) || (q_cnt_nxt != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_state <= S_IDLE;    in_cnt <= '0;   last_eng <= 1'b1;
            out_state <= S_OIDLE;  out_cnt <= '0;
            q_mem <= '0; q_wr <= 1'b0; q_rd <= 1'b0; q_cnt <= '0;
            fft_1_di_en <= 1'b0; fft_1_di_re <= '0; fft_1_di_im <= '0;
            fft_2_di_en <= 1'b0; fft_2_di_re <= '0; fft_2_di_im <= '0;
            stft_en <= 1'b0; stft_sof <= 1'b0; stft_bin <= '0; stft_re <= '0; stft_im <= '0;
            drop_cnt <= '0; err <= 1'b0; busy <= 1'b0;
        end else begin
            in_state <= in_state_nxt;   in_cnt <= in_cnt_nxt;   last_eng <= last_eng_nxt;
            out_state <= out_state_nxt; out_cnt <= out_cnt_nxt;
            q_mem <= q_mem_nxt; q_wr <= q_wr_nxt; q_rd <= q_rd_nxt; q_cnt <= q_cnt_nxt;
            fft_1_di_en <= d1_en; fft_1_di_re <= d1_re; fft_1_di_im <= d1_im;
            fft_2_di_en <= d2_en; fft_2_di_re <= d2_re; fft_2_di_im <= d2_im;
            stft_en <= so_en; stft_sof <= so_sof; stft_bin <= so_bin;
            stft_re <= so_re; stft_im <= so_im;
            drop_cnt <= drop_nxt; err <= err_nxt; busy <= busy_nxt;
        end
    end

endmodule
